// File: rtl/transform_writer.sv
// transform_writer: packs an ASCII byte stream into {lhs, rhs} words for the
// character memory and writes one {len, start} line pointer per line.
//
// state | meaning
// LHS   | waiting for the first character of a pair (or a control byte)
// RHS   | lhs held, waiting for the second character of the pair
// PADWR | writing the space-padded final word of an odd-length line
// PTR   | writing the line-pointer entry for the line just closed
// DONE  | end of stream seen, idle until reset
// ERR   | memory or pointer table overflow, idle until reset
module transform_writer #(
  parameter int          MAX_LINES = 16,
  parameter logic [7:0]  LAST_ADDR = 8'hFE,
  parameter logic [7:0]  PAD_CHAR  = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_char,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_din,
  output logic        ptr_we,
  output logic [7:0]  ptr_line,
  output logic [15:0] ptr_data,
  output logic [7:0]  line_count,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] CH_EOL     = 8'h0A;
  localparam logic [7:0] CH_EOS     = 8'h04;
  localparam logic [7:0] LINE_LIMIT = 8'(MAX_LINES);

  typedef enum logic [2:0] {
    S_LHS,
    S_RHS,
    S_PADWR,
    S_PTR,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  logic [7:0]  wr_addr;
  logic [7:0]  line_start;
  logic [7:0]  len;
  logic [7:0]  line_idx;
  logic [7:0]  hold_lhs;
  logic [15:0] pad_word;

  logic        xfer;
  logic        is_eol;
  logic        is_eos;
  logic        addr_full;
  logic [15:0] rhs_word;

  // Decode the incoming byte and build the word an RHS accept would write.
  always_comb begin
    xfer      = in_valid && in_ready;
    is_eol    = (in_char == CH_EOL);
    is_eos    = (in_char == CH_EOS);
    addr_full = (wr_addr > LAST_ADDR);
    rhs_word  = is_eos ? {hold_lhs, PAD_CHAR} : {hold_lhs, in_char};
  end

  // Line count is simply the number of pointer entries written so far.
  assign line_count = line_idx;

  // Main controller: state, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_LHS;
      wr_addr    <= 8'h00;
      line_start <= 8'h00;
      len        <= 8'h00;
      line_idx   <= 8'h00;
      hold_lhs   <= 8'h00;
      pad_word   <= 16'h2020;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 8'h00;
      mem_din    <= 16'h2020;
      ptr_we     <= 1'b0;
      ptr_line   <= 8'h00;
      ptr_data   <= 16'h0000;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      ptr_we <= 1'b0;
      case (state)
        S_LHS: begin
          in_ready <= 1'b1;
          if (xfer) begin
            if (is_eol) begin
              state    <= S_PTR;
              in_ready <= 1'b0;
            end else if (is_eos) begin
              // partial line with no characters pending: nothing to write
              state    <= S_DONE;
              in_ready <= 1'b0;
            end else begin
              hold_lhs <= in_char;
              state    <= S_RHS;
            end
          end
        end

        S_RHS: begin
          if (xfer) begin
            if (is_eol) begin
              pad_word <= {hold_lhs, PAD_CHAR};
              state    <= S_PADWR;
              in_ready <= 1'b0;
            end else if (addr_full) begin
              state    <= S_ERR;
              in_ready <= 1'b0;
            end else begin
              // word is written on the accept edge so pairs stream at full rate
              mem_we   <= 1'b1;
              mem_addr <= wr_addr;
              mem_din  <= rhs_word;
              wr_addr  <= wr_addr + 8'd1;
              len      <= len + 8'd1;
              state    <= is_eos ? S_DONE : S_LHS;
              in_ready <= !is_eos;
            end
          end
        end

        S_PADWR: begin
          in_ready <= 1'b0;
          if (addr_full) begin
            state <= S_ERR;
          end else begin
            mem_we   <= 1'b1;
            mem_addr <= wr_addr;
            mem_din  <= pad_word;
            wr_addr  <= wr_addr + 8'd1;
            len      <= len + 8'd1;
            state    <= S_PTR;
          end
        end

        S_PTR: begin
          if (line_idx == LINE_LIMIT) begin
            state    <= S_ERR;
            in_ready <= 1'b0;
          end else begin
            // wr_addr already points past the line, so it starts the next one
            ptr_we     <= 1'b1;
            ptr_line   <= line_idx;
            ptr_data   <= {len, line_start};
            line_idx   <= line_idx + 8'd1;
            line_start <= wr_addr;
            len        <= 8'h00;
            state      <= S_LHS;
            in_ready   <= 1'b1;
          end
        end

        S_DONE: begin
          in_ready <= 1'b0;
          done     <= 1'b1;
        end

        S_ERR: begin
          in_ready <= 1'b0;
          err      <= 1'b1;
        end

        default: begin
          state    <= S_ERR;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transform_writer.sv
// Directed bench for transform_writer: byte streams in, captured memory and
// pointer writes compared against hand-computed values.
module tb_transform_writer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_char;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_din;
  logic        ptr_we;
  logic [7:0]  ptr_line;
  logic [15:0] ptr_data;
  logic [7:0]  line_count;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [15:0] cap_mem [256];
  logic [15:0] cap_ptr [256];
  int          mem_cnt  = 0;
  int          ptr_cnt  = 0;
  int          both_cnt = 0;
  logic [7:0]  last_mem_addr = 8'h00;

  int mem_base;
  int ptr_base;
  int both_base;

  transform_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_char    (in_char),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .ptr_we     (ptr_we),
    .ptr_line   (ptr_line),
    .ptr_data   (ptr_data),
    .line_count (line_count),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every strobe on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        cap_mem[mem_addr] = mem_din;
        last_mem_addr     = mem_addr;
        mem_cnt++;
      end
      if (ptr_we) begin
        cap_ptr[ptr_line] = ptr_data;
        ptr_cnt++;
      end
      if (mem_we && ptr_we) both_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    mem_base  = mem_cnt;
    ptr_base  = ptr_cnt;
    both_base = both_cnt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_char  = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mark();
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(n), 32'd0);
    in_char  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_char  = 8'h00;

    // reset values while held in reset
    idle(2);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_ptr_we", 32'(ptr_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h00);
    chk("rst_mem_din", 32'(mem_din), 32'h2020);
    chk("rst_ptr_data", 32'(ptr_data), 32'h0000);
    chk("rst_line_count", 32'(line_count), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);

    // "111s " then newline: two full pairs, one padded word, len 3
    do_reset();
    send(8'h31); send(8'h31); send(8'h31); send(8'h73); send(8'h20); send(8'h0A);
    idle(4);
    chk("t1_mem_cnt", 32'(mem_cnt - mem_base), 32'd3);
    chk("t1_mem0", 32'(cap_mem[0]), 32'h3131);
    chk("t1_mem1", 32'(cap_mem[1]), 32'h3173);
    chk("t1_mem2", 32'(cap_mem[2]), 32'h2020);
    chk("t1_ptr_cnt", 32'(ptr_cnt - ptr_base), 32'd1);
    chk("t1_ptr0", 32'(cap_ptr[0]), 32'h0300);
    chk("t1_line_count", 32'(line_count), 32'd1);
    chk("t1_in_ready", 32'(in_ready), 32'd1);

    // "ab\n" "c\n"
    do_reset();
    send(8'h61); send(8'h62); send(8'h0A); send(8'h63); send(8'h0A);
    idle(4);
    chk("t2_mem0", 32'(cap_mem[0]), 32'h6162);
    chk("t2_mem1", 32'(cap_mem[1]), 32'h6320);
    chk("t2_ptr0", 32'(cap_ptr[0]), 32'h0100);
    chk("t2_ptr1", 32'(cap_ptr[1]), 32'h0101);
    chk("t2_mem_cnt", 32'(mem_cnt - mem_base), 32'd2);
    chk("t2_ptr_cnt", 32'(ptr_cnt - ptr_base), 32'd2);
    chk("t2_coincide", 32'(both_cnt - both_base), 32'd0);
    chk("t2_line_count", 32'(line_count), 32'd2);

    // empty line then end of stream
    do_reset();
    send(8'h0A); send(8'h04);
    idle(3);
    chk("t3_ptr_cnt", 32'(ptr_cnt - ptr_base), 32'd1);
    chk("t3_ptr0", 32'(cap_ptr[0]), 32'h0000);
    chk("t3_mem_cnt", 32'(mem_cnt - mem_base), 32'd0);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    chk("t3_err", 32'(err), 32'd0);

    // fill all 255 words, then one more pair overflows
    do_reset();
    for (int i = 0; i < 510; i++) send(8'h78);
    idle(2);
    chk("t4_mem_cnt", 32'(mem_cnt - mem_base), 32'd255);
    chk("t4_last_addr", 32'(last_mem_addr), 32'hFE);
    chk("t4_memFE", 32'(cap_mem[8'hFE]), 32'h7878);
    chk("t4_err_early", 32'(err), 32'd0);
    send(8'h79); send(8'h7A);
    idle(3);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    chk("t4_no_extra", 32'(mem_cnt - mem_base), 32'd255);

    // MAX_LINES empty lines, then one more newline overflows the pointer table
    do_reset();
    for (int i = 0; i < 17; i++) send(8'h0A);
    idle(4);
    chk("t5_ptr_cnt", 32'(ptr_cnt - ptr_base), 32'd16);
    chk("t5_ptr15", 32'(cap_ptr[15]), 32'h0000);
    chk("t5_line_count", 32'(line_count), 32'd16);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_in_ready", 32'(in_ready), 32'd0);

    // reset right after an RHS accept abandons the write
    do_reset();
    send(8'h41);
    in_char  = 8'h42;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t6_mem_we", 32'(mem_we), 32'd0);
    chk("t6_mem_addr", 32'(mem_addr), 32'h00);
    chk("t6_mem_din", 32'(mem_din), 32'h2020);
    chk("t6_in_ready", 32'(in_ready), 32'd0);
    chk("t6_outs", 32'({ptr_we, ptr_line, ptr_data, line_count, done, err}), 32'd0);
    idle(2);
    chk("t6_mem_cnt", 32'(mem_cnt - mem_base), 32'd0);
    rst_n = 1'b1;
    send(8'h43); send(8'h44); send(8'h0A);
    idle(4);
    chk("t6_restart_addr", 32'(last_mem_addr), 32'h00);
    chk("t6_restart_mem0", 32'(cap_mem[0]), 32'h4344);
    chk("t6_restart_ptr0", 32'(cap_ptr[0]), 32'h0100);
    chk("t6_restart_lines", 32'(line_count), 32'd1);
    chk("t6_coincide", 32'(both_cnt - both_base), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
